// File: rtl/handshaked_fifo_param.sv
// Handshaked register-array FIFO with first-word fall-through output and an
// occupancy count; feeds the `a` input of the downstream pass-through stage.
module handshaked_fifo_param #(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        dataIn_data,
    input  logic                         dataIn_vld,
    output logic                         dataIn_rd,
    output logic [DATA_WIDTH-1:0]        dataOut_data,
    output logic                         dataOut_vld,
    input  logic                         dataOut_rd,
    output logic [$clog2(DEPTH):0]       size
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      size_q, size_d;
    logic                  wr_en;
    logic                  rd_en;

    // Status flags depend only on registered occupancy (plus rst gating ready).
    assign dataIn_rd    = !rst && (size_q != FULL_CNT);
    assign dataOut_vld  = (size_q != '0);
    assign dataOut_data = mem_q[rd_ptr_q];
    assign size         = size_q;

    assign wr_en = dataIn_vld && dataIn_rd;
    assign rd_en = dataOut_vld && dataOut_rd;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        size_d   = size_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = dataIn_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Simultaneous read and write leaves the occupancy unchanged.
        case ({wr_en, rd_en})
            2'b10:   size_d = size_q + CNT_ONE;
            2'b01:   size_d = size_q - CNT_ONE;
            default: size_d = size_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            size_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            size_q   <= size_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_handshaked_fifo_param.sv
// Bench for handshaked_fifo_param: directed steps on a 2-bit/4-deep instance,
// randomized duplex traffic on a 3-bit/8-deep instance, both against queue models.
module tb_handshaked_fifo_param;
    logic clk;
    int   checks = 0;
    int   errors = 0;

    // Instance A: DATA_WIDTH=2, DEPTH=4
    logic       rst_a;
    logic [1:0] a_in_data;
    logic       a_in_vld;
    logic       a_in_rd;
    logic [1:0] a_out_data;
    logic       a_out_vld;
    logic       a_out_rd;
    logic [2:0] a_size;

    // Instance B: DATA_WIDTH=3, DEPTH=8
    logic       rst_b;
    logic [2:0] b_in_data;
    logic       b_in_vld;
    logic       b_in_rd;
    logic [2:0] b_out_data;
    logic       b_out_vld;
    logic       b_out_rd;
    logic [3:0] b_size;

    handshaked_fifo_param #(.DATA_WIDTH(2), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst_a),
        .dataIn_data(a_in_data), .dataIn_vld(a_in_vld), .dataIn_rd(a_in_rd),
        .dataOut_data(a_out_data), .dataOut_vld(a_out_vld), .dataOut_rd(a_out_rd),
        .size(a_size)
    );

    handshaked_fifo_param #(.DATA_WIDTH(3), .DEPTH(8)) dut_b (
        .clk(clk), .rst(rst_b),
        .dataIn_data(b_in_data), .dataIn_vld(b_in_vld), .dataIn_rd(b_in_rd),
        .dataOut_data(b_out_data), .dataOut_vld(b_out_vld), .dataOut_rd(b_out_rd),
        .size(b_size)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [1:0] qa [$];
    logic [2:0] qb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance A; inputs applied #1 after the previous edge.
    task automatic cyc_a(input logic v, input logic [1:0] d, input logic r);
        logic wr, rd;
        a_in_vld  = v;
        a_in_data = d;
        a_out_rd  = r;
        #1;
        chk("a_in_rd_pre", 32'(a_in_rd), 32'(qa.size() < 4));
        chk("a_out_vld_pre", 32'(a_out_vld), 32'(qa.size() > 0));
        if (qa.size() > 0) chk("a_head", 32'(a_out_data), 32'(qa[0]));
        wr = v && (qa.size() < 4);
        rd = r && (qa.size() > 0);
        @(posedge clk);
        #1;
        if (rd) void'(qa.pop_front());
        if (wr) qa.push_back(d);
        chk("a_size", 32'(a_size), 32'(qa.size()));
    endtask

    task automatic cyc_b(input logic v, input logic [2:0] d, input logic r,
                         output logic wr, output logic rd);
        b_in_vld  = v;
        b_in_data = d;
        b_out_rd  = r;
        #1;
        chk("b_in_rd", 32'(b_in_rd), 32'(qb.size() < 8));
        chk("b_out_vld", 32'(b_out_vld), 32'(qb.size() > 0));
        if (qb.size() > 0) chk("b_head", 32'(b_out_data), 32'(qb[0]));
        wr = v && (qb.size() < 8);
        rd = r && (qb.size() > 0);
        @(posedge clk);
        #1;
        if (rd) void'(qb.pop_front());
        if (wr) qb.push_back(d);
        chk("b_size", 32'(b_size), 32'(qb.size()));
    endtask

    initial begin
        logic [1:0] fill_words [4];
        logic [1:0] sim_in [10];
        logic       wr, rd, hold;
        bit         seen [8];
        int         cnt;

        fill_words = '{2'd1, 2'd2, 2'd3, 2'd0};
        rst_a = 1'b1; a_in_vld = 1'b0; a_in_data = '0; a_out_rd = 1'b0;
        rst_b = 1'b1; b_in_vld = 1'b0; b_in_data = '0; b_out_rd = 1'b0;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;

        // Reset state
        #2;
        chk("rst_in_rd", 32'(a_in_rd), 32'd0);
        chk("rst_out_vld", 32'(a_out_vld), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_size", 32'(a_size), 32'd0);
        chk("rst_b_in_rd", 32'(b_in_rd), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("rel_in_rd", 32'(a_in_rd), 32'd1);
        @(posedge clk);
        #1;

        // Fill 1,2,3,0
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b1, fill_words[i], 1'b0);
            chk("fill_size", 32'(a_size), 32'(i + 1));
        end
        chk("full_in_rd", 32'(a_in_rd), 32'd0);
        // Fifth word is refused and the head stays put
        for (int i = 0; i < 2; i++) begin
            cyc_a(1'b1, 2'd2, 1'b0);
            chk("full_hold_size", 32'(a_size), 32'd4);
            chk("full_hold_head", 32'(a_out_data), 32'd1);
        end

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            a_in_vld = 1'b0; a_out_rd = 1'b1;
            #1;
            chk("drain_data", 32'(a_out_data), 32'(fill_words[i]));
            cyc_a(1'b0, 2'd0, 1'b1);
            chk("drain_size", 32'(a_size), 32'(3 - i));
            chk("drain_in_rd", 32'(a_in_rd), 32'd1);
        end
        chk("drain_out_vld", 32'(a_out_vld), 32'd0);

        // Refill, then a read attempt while full with a pending write
        for (int i = 0; i < 4; i++) cyc_a(1'b1, fill_words[i], 1'b0);
        cyc_a(1'b1, 2'd2, 1'b1);
        chk("fullrd_size", 32'(a_size), 32'd3);
        chk("fullrd_head", 32'(a_out_data), 32'd2);
        cyc_a(1'b1, 2'd2, 1'b0);
        chk("fullrd_wr_size", 32'(a_size), 32'd4);

        // Down to size 2, then 10 cycles of simultaneous read/write
        cyc_a(1'b0, 2'd0, 1'b1);
        cyc_a(1'b0, 2'd0, 1'b1);
        chk("sim_start_size", 32'(a_size), 32'd2);
        for (int i = 0; i < 10; i++) begin
            sim_in[i] = 2'($urandom_range(0, 3));
            if (i >= 2) begin
                a_out_rd = 1'b1;
                #1;
                chk("sim_delay2", 32'(a_out_data), 32'(sim_in[i - 2]));
            end
            cyc_a(1'b1, sim_in[i], 1'b1);
            chk("sim_size", 32'(a_size), 32'd2);
        end

        // Up to size 3, then an asynchronous reset pulse between edges
        cyc_a(1'b1, 2'd1, 1'b0);
        chk("pre_rst_size", 32'(a_size), 32'd3);
        a_in_vld = 1'b0;
        rst_a = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(a_out_vld), 32'd0);
        chk("mid_rst_size", 32'(a_size), 32'd0);
        chk("mid_rst_data", 32'(a_out_data), 32'd0);
        chk("mid_rst_in_rd", 32'(a_in_rd), 32'd0);
        #1;
        rst_a = 1'b0;
        qa.delete();
        @(posedge clk);
        #1;
        cyc_a(1'b1, 2'd2, 1'b0);
        chk("post_rst_data", 32'(a_out_data), 32'd2);
        chk("post_rst_size", 32'(a_size), 32'd1);
        a_in_vld = 1'b0;

        // Randomized duplex traffic on the 3-bit, 8-deep instance
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        hold = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic       v;
            logic [2:0] d;
            if (hold) begin
                v = b_in_vld;
                d = b_in_data;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                d = 3'($urandom_range(0, 7));
            end
            if (qb.size() > 0) cnt = int'(qb[0]);
            else cnt = -1;
            cyc_b(v, d, ($urandom_range(0, 2) != 0), wr, rd);
            if (rd) seen[cnt] = 1'b1;
            hold = v && !wr;
            b_in_vld = 1'b0;
        end
        // Flush remaining words so every stored value is accounted for
        for (int i = 0; i < 8; i++) begin
            if (qb.size() > 0) cnt = int'(qb[0]);
            else cnt = -1;
            cyc_b(1'b0, 3'd0, 1'b1, wr, rd);
            if (rd) seen[cnt] = 1'b1;
        end
        chk("b_empty_size", 32'(b_size), 32'd0);
        cnt = 0;
        for (int i = 0; i < 8; i++) if (seen[i]) cnt++;
        chk("b_all_values_seen", 32'(cnt), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/handshaked_fifo_param.md
# handshaked_fifo_param

Parametrized handshaked FIFO that buffers DATA_WIDTH-bit words directly upstream of the SimpleUnitWithParam pass-through stage. It decouples the producer from the consumer side of that stage, and its output data port connects 1:1 to the stage's `a` input. It must elaborate for both supported widths (2 and 3). It also exposes an occupancy count for flow monitoring.

## Interface
Parameters:
- DATA_WIDTH, default 2: word width; supported values 2 and 3, must match the downstream stage.
- DEPTH, default 4: number of entries; power of two, at least 2.

Ports:
- clk  input  1  the single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- dataIn_data  input  DATA_WIDTH  write word.
- dataIn_vld  input  1  producer has a valid word.
- dataIn_rd  output  1  FIFO can accept a word.
- dataOut_data  output  DATA_WIDTH  head word; drives `a` of the downstream stage.
- dataOut_vld  output  1  head word is valid.
- dataOut_rd  input  1  consumer accepts the head word.
- size  output  log2(DEPTH)+1  current number of stored words, 0..DEPTH.

## Operation
- Write transfer: `dataIn_vld & dataIn_rd` sampled at a rising edge. Read transfer: `dataOut_vld & dataOut_rd` sampled at a rising edge.
- Storage: register array of DEPTH words.
  - wr_ptr and rd_ptr are each log2(DEPTH) bits wide.
  - Both pointers wrap modulo DEPTH by natural overflow.
- Occupancy counter `size`:
  - Increments on a write-only cycle.
  - Decrements on a read-only cycle.
  - Holds on a cycle with both transfers or with neither.
  - Never exceeds DEPTH. Never underflows.
- `dataIn_rd = (size != DEPTH)`. When full, a same-cycle read does not enable a write; there is no full pass-through.
- `dataOut_vld = (size != 0)`. When empty, no bypass; a write is not visible until the next cycle.
- `dataOut_data = mem[rd_ptr]`, a combinational read of the register array. The value is stable while `dataOut_vld & !dataOut_rd`.
- On a write, the word is stored at mem[wr_ptr] and wr_ptr advances. On a read, rd_ptr advances. Stored contents are not otherwise modified.
- Data ordering is strictly FIFO. No word is dropped or duplicated.
- Handshake rules:
  - The producer must hold dataIn_data stable while `dataIn_vld & !dataIn_rd`.
  - The FIFO holds dataOut_data and dataOut_vld while `dataOut_vld & !dataOut_rd`.
- Reset (async, takes effect immediately, independent of clk):
  - wr_ptr = 0, rd_ptr = 0, size = 0, all mem entries = 0.
  - Therefore dataOut_vld = 0 and dataOut_data = 0.
  - dataIn_rd is forced to 0 while rst is high.
  - Any in-flight contents are discarded.

## Timing
- Write-to-output latency: 1 cycle. A word written at edge N is presented with dataOut_vld = 1 after edge N (first-word fall-through).
- Throughput: 1 word per cycle when neither full nor empty.
- Status outputs: size, dataIn_rd and dataOut_vld are registered-state derived and change only after a clock edge or on rst assertion. They have no combinational path from dataIn_vld or dataOut_rd.
- Reset release: the first write is accepted at the first rising edge after rst deasserts. dataIn_rd = 1 during that cycle.
- Reset values of outputs: dataIn_rd 0 while rst high, then 1. dataOut_vld 0, dataOut_data 0, size 0.

## Test plan
- Fill: DATA_WIDTH=2, DEPTH=4, dataOut_rd=0, write 1,2,3,0 on consecutive cycles, then hold dataIn_vld=1 with a fifth word -> size steps 1,2,3,4; dataIn_rd=0 after the fourth edge; the fifth word is not accepted; dataOut_data=1 stays stable.
- Drain: from the full state, dataOut_rd=1 for 4 cycles -> outputs 1,2,3,0 in order; size 3,2,1,0; dataOut_vld=0 after the fourth edge; dataIn_rd=1 after the first read.
- Simultaneous read and write at size=2, continuous for 10 cycles -> size constant at 2; pointers wrap at least twice; output sequence equals input sequence delayed by 2 words.
- Full with a same-cycle read attempt: at size=4 with dataIn_vld=1 and dataOut_rd=1 -> only the read completes, size=3; the held input word is written on the next edge.
- Mid-operation reset: at size=3, pulse rst for half a cycle between edges -> dataOut_vld=0, size=0 and dataOut_data=0 immediately. After release, write 2 -> dataOut_data=2 after one edge, size=1.
- DATA_WIDTH=3, DEPTH=8 with a random vld/rd duplex for 1000 cycles, checked against a reference queue -> no loss, reorder or duplication; size always equals the model's occupancy; values 0..7 all observed.
